// File: rtl/tick_timer.sv
// Programmable down-counting tick timer with one-shot/auto-reload modes,
// a sticky interrupt flag with acknowledge, and overrun detection.
module tick_timer #(
  parameter int unsigned  W          = 16,
  parameter logic [W-1:0] RST_RELOAD = '0
) (
  input  logic         clk_50,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         start,
  input  logic         stop,
  input  logic         auto_reload,
  input  logic         irq_ack,
  output logic [W-1:0] cnt,
  output logic         busy,
  output logic         expired,
  output logic         irq,
  output logic         overrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] reload_q, reload_d;
  logic         busy_q, busy_d;
  logic         expired_q, expired_d;
  logic         irq_q, irq_d;
  logic         overrun_q, overrun_d;
  logic         expire_c;

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      reload_q  <= RST_RELOAD;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      irq_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
      irq_q     <= irq_d;
      overrun_q <= overrun_d;
    end
  end

  // Control decode, priority stop > load > start > tick.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    expire_c = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
    end else if (load) begin
      reload_d = load_val;
      cnt_d    = load_val;
      if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
      end
    end else if (start && (state_q != ST_RUN)) begin
      if (reload_q != '0) begin
        cnt_d   = reload_q;
        state_d = ST_RUN;
      end
    end else if (tick && (state_q == ST_RUN)) begin
      // A zero count can only reach RUN via load_val=0; treat it as expiring
      // so the counter never wraps to all-ones.
      if (cnt_q > W'(1)) begin
        cnt_d = cnt_q - W'(1);
      end else begin
        expire_c = 1'b1;
        if (auto_reload) begin
          cnt_d = reload_q;
        end else begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
    end
  end

  // Status flags: expiry set wins over acknowledge for irq.
  always_comb begin
    busy_d    = (state_d == ST_RUN);
    expired_d = expire_c;
    irq_d     = irq_q;
    overrun_d = overrun_q;

    if (expire_c) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end

    if (irq_ack) begin
      overrun_d = 1'b0;
    end else if (expire_c && irq_q) begin
      overrun_d = 1'b1;
    end
  end

  assign cnt     = cnt_q;
  assign busy    = busy_q;
  assign expired = expired_q;
  assign irq     = irq_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_tick_timer.sv
// Directed self-checking bench for tick_timer.
module tb_tick_timer;

  localparam int unsigned W = 16;

  logic         clk_50;
  logic         rst_n;
  logic         tick;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         stop;
  logic         auto_reload;
  logic         irq_ack;
  logic [W-1:0] cnt;
  logic         busy;
  logic         expired;
  logic         irq;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  tick_timer #(.W(W), .RST_RELOAD(16'd0)) dut (
    .clk_50      (clk_50),
    .rst_n       (rst_n),
    .tick        (tick),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .irq_ack     (irq_ack),
    .cnt         (cnt),
    .busy        (busy),
    .expired     (expired),
    .irq         (irq),
    .overrun     (overrun)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk_50);
    #1;
  endtask

  task automatic tick_once(input int gap);
    repeat (gap) cycle();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] c, input logic b,
                           input logic e, input logic i, input logic o);
    check_eq({tag, ".cnt"}, 32'(cnt), 32'(c));
    check_eq({tag, ".busy"}, 32'(busy), 32'(b));
    check_eq({tag, ".expired"}, 32'(expired), 32'(e));
    check_eq({tag, ".irq"}, 32'(irq), 32'(i));
    check_eq({tag, ".overrun"}, 32'(overrun), 32'(o));
  endtask

  initial begin
    rst_n       = 1'b0;
    tick        = 1'b0;
    load        = 1'b0;
    load_val    = '0;
    start       = 1'b0;
    stop        = 1'b0;
    auto_reload = 1'b0;
    irq_ack     = 1'b0;

    // Reset held with ticks pulsing
    tick = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_all("rst", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick  = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      check_all("idle", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // One-shot, reload 5, tick every 10th cycle
    load_val = 16'd5;
    load     = 1'b1;
    cycle();
    load = 1'b0;
    check_all("os_load", 16'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check_all("os_start", 16'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick_once(9);
      check_all("os_tick", 16'(5 - k), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    tick_once(9);
    check_all("os_expire", 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle();
    check_eq("os_pulse_end", 32'(expired), 32'd0);
    tick_once(3);
    check_all("os_done_tick", 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
    check_eq("os_ack_irq", 32'(irq), 32'd0);

    // Auto-reload period 3, nine ticks without ack
    auto_reload = 1'b1;
    load_val    = 16'd3;
    load        = 1'b1;
    cycle();
    load = 1'b0;
    check_all("ar_load", 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check_eq("ar_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 9; k++) begin
      tick_once(1);
      check_all("ar_tick", (k % 3 == 0) ? 16'd3 : 16'(3 - (k % 3)), 1'b1,
                (k % 3 == 0), (k >= 3), (k >= 6));
    end
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
    check_all("ar_ack", 16'd3, 1'b1, 1'b0, 1'b0, 1'b0);

    // Expiry coincident with acknowledge
    for (int k = 0; k < 3; k++) tick_once(1);
    check_all("col_pre", 16'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    tick_once(1);
    tick_once(1);
    check_eq("col_cnt1", 32'(cnt), 32'd1);
    tick    = 1'b1;
    irq_ack = 1'b1;
    cycle();
    tick    = 1'b0;
    irq_ack = 1'b0;
    check_all("col_hit", 16'd3, 1'b1, 1'b1, 1'b1, 1'b0);

    // Priority and mid-run control
    load_val = 16'd4;
    load     = 1'b1;
    cycle();
    load = 1'b0;
    check_all("pr_load4", 16'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    load_val = 16'd7;
    load     = 1'b1;
    tick     = 1'b1;
    cycle();
    load = 1'b0;
    tick = 1'b0;
    check_eq("pr_load_tick_cnt", 32'(cnt), 32'd7);
    check_eq("pr_load_tick_busy", 32'(busy), 32'd1);
    stop  = 1'b1;
    start = 1'b1;
    cycle();
    stop  = 1'b0;
    start = 1'b0;
    check_eq("pr_stop_cnt", 32'(cnt), 32'd7);
    check_eq("pr_stop_busy", 32'(busy), 32'd0);
    tick_once(0);
    check_eq("pr_idle_tick", 32'(cnt), 32'd7);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check_eq("pr_start_cnt", 32'(cnt), 32'd7);
    check_eq("pr_start_busy", 32'(busy), 32'd1);
    tick_once(0);
    check_eq("pr_run_tick", 32'(cnt), 32'd6);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check_eq("pr_restart_ignored", 32'(cnt), 32'd6);

    // Full-range reload
    stop = 1'b1;
    cycle();
    stop     = 1'b0;
    load_val = 16'hFFFF;
    load     = 1'b1;
    cycle();
    load  = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check_eq("fr_start_cnt", 32'(cnt), 32'hFFFF);
    tick_once(0);
    check_eq("fr_tick_cnt", 32'(cnt), 32'hFFFE);

    // Zero reload: start ignored
    stop    = 1'b1;
    irq_ack = 1'b1;
    cycle();
    stop     = 1'b0;
    irq_ack  = 1'b0;
    load_val = 16'd0;
    load     = 1'b1;
    cycle();
    load  = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check_all("zr_start", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick_once(0);
      check_all("zr_tick", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset mid-count aborts without expiry and restores zero reload
    auto_reload = 1'b0;
    load_val    = 16'd5;
    load        = 1'b1;
    cycle();
    load  = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    tick_once(0);
    check_eq("mr_cnt4", 32'(cnt), 32'd4);
    rst_n = 1'b0;
    tick  = 1'b1;
    cycle();
    tick  = 1'b0;
    rst_n = 1'b1;
    check_all("mr_reset", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check_all("mr_start_zero", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
